// File: rtl/add_n_in_packer.sv
// Packs num_elems data_width-bit elements (valid/ready in) into one registered wide vector (valid/ready out).
// Define ADD_N_PACKER_MSB_FIRST_EN to place the first received element in the top slice instead of slot 0.
module add_n_in_packer #(
    parameter int unsigned data_width = 2,
    parameter int unsigned num_elems  = 2
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [data_width-1:0]           in_data,
    input  logic                            in_valid,
    output logic                            in_ready,
    output logic [num_elems*data_width-1:0] out_data,
    output logic                            out_valid,
    input  logic                            out_ready
);

    localparam int unsigned IDX_W = (num_elems > 1) ? $clog2(num_elems) : 1;

    typedef enum logic {
        FILL = 1'b0,
        FULL = 1'b1
    } state_t;

    state_t                          state, state_n;
    logic [IDX_W-1:0]                idx, idx_n;
    logic [num_elems*data_width-1:0] data_n;
    logic                            accept;
    logic                            drain;

    function automatic int unsigned slot_of(input logic [IDX_W-1:0] k);
`ifdef ADD_N_PACKER_MSB_FIRST_EN
        return (num_elems - 1) - int'(k);
`else
        return int'(k);
`endif
    endfunction

    assign in_ready  = !rst && ((state == FILL) || out_ready);
    assign out_valid = (state == FULL);
    assign accept    = in_valid && in_ready;
    assign drain     = (state == FULL) && out_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= FILL;
            idx      <= '0;
            out_data <= '0;
        end else begin
            state    <= state_n;
            idx      <= idx_n;
            out_data <= data_n;
        end
    end

    always_comb begin
        state_n = state;
        idx_n   = idx;
        data_n  = out_data;
        case (state)
            FILL: begin
                if (accept) begin
                    data_n[slot_of(idx)*data_width +: data_width] = in_data;
                    if (idx == IDX_W'(num_elems - 1)) begin
                        state_n = FULL;
                        idx_n   = '0;
                    end else begin
                        idx_n = idx + 1'b1;
                    end
                end
            end
            FULL: begin
                if (drain) begin
                    // A same-cycle accept starts the next vector at slot 0, keeping the stream gap-free.
                    if (accept) begin
                        data_n[slot_of('0)*data_width +: data_width] = in_data;
                        if (num_elems == 1) begin
                            state_n = FULL;
                            idx_n   = '0;
                        end else begin
                            state_n = FILL;
                            idx_n   = IDX_W'(1);
                        end
                    end else begin
                        state_n = FILL;
                        idx_n   = '0;
                    end
                end
            end
            default: begin
                state_n = FILL;
                idx_n   = '0;
            end
        endcase
    end

endmodule

// File: tb/tb_add_n_in_packer.sv
// Self-checking bench for add_n_in_packer: table-driven cycles on a 2x2-bit packer plus
// hand-written sequences for throughput and the single-element configuration.
module tb_add_n_in_packer;

    logic       clk = 1'b0;
    always #5 clk = ~clk;

    // num_elems = 2 instance
    logic       rst, in_valid, in_ready, out_valid, out_ready;
    logic [1:0] in_data;
    logic [3:0] out_data;

    // num_elems = 1 instance
    logic       rst1, in_valid1, in_ready1, out_valid1, out_ready1;
    logic [1:0] in_data1;
    logic [1:0] out_data1;

    add_n_in_packer #(.data_width(2), .num_elems(2)) u_dut (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready)
    );

    add_n_in_packer #(.data_width(2), .num_elems(1)) u_dut1 (
        .clk(clk), .rst(rst1), .in_data(in_data1), .in_valid(in_valid1), .in_ready(in_ready1),
        .out_data(out_data1), .out_valid(out_valid1), .out_ready(out_ready1)
    );

    int unsigned passed = 0;
    int unsigned total  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h, required %0h", name, act, exp);
    endtask

    // Expected 2-element vector given element 0 and element 1 in arrival order.
    function automatic logic [3:0] pk(input logic [1:0] e0, input logic [1:0] e1);
`ifdef ADD_N_PACKER_MSB_FIRST_EN
        return {e0, e1};
`else
        return {e1, e0};
`endif
    endfunction

    typedef struct {
        logic       rst;
        logic       iv;
        logic [1:0] id;
        logic       ordy;
        logic       exp_ir;   // in_ready before the edge
        logic       exp_ov;   // out_valid after the edge
        logic [3:0] exp_od;   // out_data after the edge
    } vec_t;

    function automatic vec_t mk(input logic r, input logic iv, input logic [1:0] id, input logic ordy,
                                input logic ir, input logic ov, input logic [3:0] od);
        vec_t v;
        v.rst = r; v.iv = iv; v.id = id; v.ordy = ordy;
        v.exp_ir = ir; v.exp_ov = ov; v.exp_od = od;
        return v;
    endfunction

    vec_t vecs[$];

    initial begin
        int unsigned nvec;
        int unsigned ir_low;

        rst = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
        rst1 = 1'b1; in_valid1 = 1'b0; in_data1 = '0; out_ready1 = 1'b0;

        //          rst   iv    id  ordy  ir    ov    od
        // reset with an accept attempt that must be discarded
        vecs.push_back(mk(1'b1, 1'b1, 2'd3, 1'b1, 1'b0, 1'b0, 4'h0));
        // basic pack 3, 1
        vecs.push_back(mk(1'b0, 1'b1, 2'd3, 1'b1, 1'b1, 1'b0, pk(2'd3, 2'd0)));
        vecs.push_back(mk(1'b0, 1'b1, 2'd1, 1'b1, 1'b1, 1'b1, pk(2'd3, 2'd1)));
        // streaming 1, 2, 3, 0 (first element drains the previous vector)
        vecs.push_back(mk(1'b0, 1'b1, 2'd1, 1'b1, 1'b1, 1'b0, pk(2'd1, 2'd1)));
        vecs.push_back(mk(1'b0, 1'b1, 2'd2, 1'b1, 1'b1, 1'b1, pk(2'd1, 2'd2)));
        vecs.push_back(mk(1'b0, 1'b1, 2'd3, 1'b1, 1'b1, 1'b0, pk(2'd3, 2'd2)));
        vecs.push_back(mk(1'b0, 1'b1, 2'd0, 1'b1, 1'b1, 1'b1, pk(2'd3, 2'd0)));
        // backpressure: fill 2, 2 then hold out_ready low for 5 cycles
        vecs.push_back(mk(1'b0, 1'b1, 2'd2, 1'b1, 1'b1, 1'b0, pk(2'd2, 2'd0)));
        vecs.push_back(mk(1'b0, 1'b1, 2'd2, 1'b1, 1'b1, 1'b1, 4'hA));
        for (int i = 0; i < 5; i++)
            vecs.push_back(mk(1'b0, 1'b1, 2'd1, 1'b0, 1'b0, 1'b1, 4'hA));
        // drain and accept element 1 into slot 0 in the same cycle
        vecs.push_back(mk(1'b0, 1'b1, 2'd1, 1'b1, 1'b1, 1'b0, pk(2'd1, 2'd2)));
        vecs.push_back(mk(1'b0, 1'b1, 2'd0, 1'b1, 1'b1, 1'b1, pk(2'd1, 2'd0)));
        vecs.push_back(mk(1'b0, 1'b0, 2'd0, 1'b1, 1'b1, 1'b0, pk(2'd1, 2'd0)));
        // reset mid-fill: accept 3, pulse rst, then 2, 1
        vecs.push_back(mk(1'b0, 1'b1, 2'd3, 1'b1, 1'b1, 1'b0, pk(2'd3, 2'd0)));
        vecs.push_back(mk(1'b1, 1'b1, 2'd2, 1'b1, 1'b0, 1'b0, 4'h0));
        vecs.push_back(mk(1'b0, 1'b1, 2'd2, 1'b1, 1'b1, 1'b0, pk(2'd2, 2'd0)));
        vecs.push_back(mk(1'b0, 1'b1, 2'd1, 1'b1, 1'b1, 1'b1, pk(2'd2, 2'd1)));
        // reset while FULL, then in_data ignored without in_valid, out_ready ignored in FILL
        vecs.push_back(mk(1'b1, 1'b1, 2'd3, 1'b0, 1'b0, 1'b0, 4'h0));
        vecs.push_back(mk(1'b0, 1'b0, 2'd3, 1'b1, 1'b1, 1'b0, 4'h0));
        vecs.push_back(mk(1'b0, 1'b1, 2'd1, 1'b0, 1'b1, 1'b0, pk(2'd1, 2'd0)));
        vecs.push_back(mk(1'b0, 1'b1, 2'd3, 1'b0, 1'b1, 1'b1, pk(2'd1, 2'd3)));
        vecs.push_back(mk(1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b1, pk(2'd1, 2'd3)));
        vecs.push_back(mk(1'b0, 1'b0, 2'd0, 1'b1, 1'b1, 1'b0, pk(2'd1, 2'd3)));

        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            rst = vecs[i].rst; in_valid = vecs[i].iv; in_data = vecs[i].id; out_ready = vecs[i].ordy;
            #1;
            chk($sformatf("v%0d in_ready", i), 32'(in_ready), 32'(vecs[i].exp_ir));
            @(posedge clk);
            #1;
            chk($sformatf("v%0d out_valid", i), 32'(out_valid), 32'(vecs[i].exp_ov));
            chk($sformatf("v%0d out_data", i), 32'(out_data), 32'(vecs[i].exp_od));
        end

        // Throughput: 8 cycles of continuous valid/ready must yield 4 vectors with in_ready never low.
        nvec = 0; ir_low = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            rst = 1'b0; in_valid = 1'b1; in_data = 2'(i); out_ready = 1'b1;
            #1;
            if (!in_ready) ir_low++;
            @(posedge clk);
            #1;
            if (out_valid) nvec++;
            if (i == 7) chk("stream last vector", 32'(out_data), 32'(pk(2'd2, 2'd3)));
        end
        chk("stream vector count", nvec, 32'd4);
        chk("stream in_ready low cycles", ir_low, 32'd0);
        @(negedge clk);
        in_valid = 1'b0;

        // num_elems = 1: reset, then stream 0..3
        @(negedge clk);
        rst1 = 1'b1; in_valid1 = 1'b1; in_data1 = 2'd3; out_ready1 = 1'b1;
        #1;
        chk("n1 reset in_ready", 32'(in_ready1), 32'd0);
        @(posedge clk);
        #1;
        chk("n1 reset out_valid", 32'(out_valid1), 32'd0);
        chk("n1 reset out_data", 32'(out_data1), 32'd0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            rst1 = 1'b0; in_valid1 = 1'b1; in_data1 = 2'(i); out_ready1 = 1'b1;
            #1;
            chk($sformatf("n1 s%0d in_ready", i), 32'(in_ready1), 32'd1);
            @(posedge clk);
            #1;
            chk($sformatf("n1 s%0d out_valid", i), 32'(out_valid1), 32'd1);
            chk($sformatf("n1 s%0d out_data", i), 32'(out_data1), 32'(i));
        end
        // num_elems = 1 backpressure, then drain without accept
        @(negedge clk);
        in_valid1 = 1'b1; in_data1 = 2'd0; out_ready1 = 1'b0;
        #1;
        chk("n1 bp in_ready", 32'(in_ready1), 32'd0);
        @(posedge clk);
        #1;
        chk("n1 bp out_valid", 32'(out_valid1), 32'd1);
        chk("n1 bp out_data", 32'(out_data1), 32'd3);
        @(negedge clk);
        in_valid1 = 1'b0; out_ready1 = 1'b1;
        @(posedge clk);
        #1;
        chk("n1 drain out_valid", 32'(out_valid1), 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: got running, required finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/add_n_in_packer.md
# add_N_in_packer

Upstream feeder for the N-element adder: accepts `data_width`-bit elements one per cycle over a valid/ready handshake and packs `num_elems` of them into one wide vector. The packed vector drives the adder's `num_elems*data_width` input bus and is presented with its own valid/ready handshake. Sustained throughput is one element per cycle, with no bubble between consecutive vectors.

## Interface
- `data_width`, default 2, width of one element
- `num_elems`, default 2, number of elements per packed vector (≥1)
- `clk`  in  1  clock; all state updates on the rising edge
- `rst`  in  1  reset, synchronous and active-high
- `in_data`  in  `data_width`  element value
- `in_valid`  in  1  `in_data` is valid
- `in_ready`  out  1  packer accepts an element this cycle
- `out_data`  out  `num_elems*data_width`  packed vector, registered
- `out_valid`  out  1  `out_data` holds a complete vector
- `out_ready`  in  1  consumer takes the vector this cycle

## Operation
- Element accept: `in_valid && in_ready`. Vector drain: `out_valid && out_ready`.
- Internal slot index `idx` runs 0..`num_elems`-1 and gives the slot for the next accepted element.
- Element k (0-based order within a vector) is written to `out_data[k*data_width +: data_width]`; the order is LSB-first.
- State FILL:
  - `out_valid`=0; `in_ready`=1.
  - On accept: write the slot and increment `idx`.
  - If the accept is at `idx`=`num_elems`-1: go to FULL with `idx`=0.
- State FULL:
  - `out_valid`=1; `in_ready`=`out_ready`.
  - Slots are frozen until drain.
- FULL, drain without accept: go to FILL, `idx`=0.
- FULL, drain with accept in the same cycle:
  - The new element goes to slot 0.
  - `num_elems`=1: stay in FULL.
  - Otherwise: go to FILL with `idx`=1.
- Unwritten slots during FILL keep their old values. They are not visible, because `out_valid`=0.
- `in_data` is ignored when `in_valid`=0. `out_ready` is ignored in FILL.

## Timing
- Reset (`rst`=1 at an edge):
  - After the edge: state FILL, `idx`=0, `out_data`=0, `out_valid`=0.
  - Any accept in that cycle is discarded.
- `in_ready` = !`rst` && (FILL || `out_ready`). It is combinational and is 0 in any cycle where `rst`=1.
- `out_valid` rises on the edge after the `num_elems`-th accept. Latency from the last element to the vector is 1 cycle.
- `out_data` and `out_valid` are registered only and have no combinational input-to-output path.
- Backpressure: while FULL and `out_ready`=0, `out_data` and `out_valid` hold stable and `in_ready`=0.
- With `in_valid`=`out_ready`=1 continuously, a new vector appears every `num_elems` cycles with no gaps.
- Reset mid-fill or while FULL discards the partial or held vector. The first vector after reset contains only post-reset elements.

## Configuration
- Macro `ADD_N_PACKER_MSB_FIRST_EN`.
- Undefined (default): LSB-first, element k goes to slot k.
- Defined: element k goes to slot `num_elems`-1-k, so the first element received lands in the top slice.
- The handshake, timing and reset behaviour are identical in both builds.

## Test plan
All scenarios use `data_width`=2 and `num_elems`=2 unless stated otherwise.
- **Basic pack:** Reset, then send 3, 1 on back-to-back cycles with `out_ready`=1.
  - Required: `out_valid`=1 one cycle after the second accept, `out_data`=4'h7.
  - With `ADD_N_PACKER_MSB_FIRST_EN` defined: `out_data`=4'hD.
- **Streaming:** Send 1, 2, 3, 0 continuously with `out_ready`=1.
  - Required: vectors 4'h9, then 4'h3, two cycles apart; `in_ready` stays 1 throughout.
- **Backpressure:** Fill with 2, 2, then hold `out_ready`=0 for 5 cycles with `in_valid`=1 and `in_data`=1.
  - Required: `in_ready`=0 and `out_data`=4'hA stable for all 5 cycles.
  - Raising `out_ready` drains the vector and accepts the element 1 into slot 0 in the same cycle.
- **Reset mid-operation:** Accept 3, pulse `rst` for 1 cycle, then send 2, 1.
  - Required: `out_valid`=0 and `out_data`=0 after reset; the next vector is 4'h6.
  - The same holds when `rst` is asserted while FULL.
- **Single-element vectors (`num_elems`=1):** Stream 0, 1, 2, 3 with `out_ready`=1.
  - Required: `out_valid` stays 1 from cycle 1 and `out_data` follows the inputs one cycle later.
